// File: rtl/wb_regfile.sv
// MIPS write-back stage and 32-entry general-purpose register file.
// Selects load data or ALU result, commits it on the clock edge, and serves two bypassed read ports.
module wb_regfile #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic              MEMtoReg,
  input  logic [WIDTH-1:0]  RD_in,
  input  logic [WIDTH-1:0]  ALU_result_in,
  input  logic [ADDR_W-1:0] regdst_in,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [WIDTH-1:0]  rs_data,
  output logic [WIDTH-1:0]  rt_data,
  output logic [WIDTH-1:0]  wb_data,
  output logic              wb_valid,
  output logic [31:0]       wr_count
);

  localparam int NREGS = 1 << ADDR_W;

  logic [WIDTH-1:0] regs [NREGS];
  logic [31:0]      wr_count_q;

  assign wb_data = MEMtoReg ? RD_in : ALU_result_in;

  // wb_valid marks a write that will really commit at the coming edge: writes to
  // r0 and writes while reset is held are excluded, so the bypass and counter agree.
  assign wb_valid = RegWrite & (regdst_in != '0) & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      wr_count_q <= '0;
    end else if (wb_valid) begin
      regs[regdst_in] <= wb_data;
      wr_count_q      <= wr_count_q + 32'd1;
    end
  end

  assign wr_count = wr_count_q;

  // r0 reads as zero and the current write-back value overrides the array.
  always_comb begin
    rs_data = '0;
    if (!rst && (rs_addr != '0)) begin
      rs_data = (wb_valid && (rs_addr == regdst_in)) ? wb_data : regs[rs_addr];
    end
  end

  always_comb begin
    rt_data = '0;
    if (!rst && (rt_addr != '0)) begin
      rt_data = (wb_valid && (rt_addr == regdst_in)) ? wb_data : regs[rt_addr];
    end
  end

endmodule
